tlk2711_dma_rd_arb: RTL and testbench

Round-robin arbiter that shares one DMA read (MM2S) command channel among NUM_CH TLK2711 TX command generators.
- Each requester presents a req/ack command of {saddr, byte len} and receives its own per-transfer "last" pulse back.
- Only one transfer is outstanding at a time; the next grant is issued only after the DMA reports the last beat or a timeout fires.
- Sits between the per-lane TX command generators and the DMA command/status interface.

---
 rtl/tlk2711_dma_rd_arb.sv | 183 ++++++++++++++++++
 tb/tb_tlk2711_dma_rd_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_dma_rd_arb.sv
// Round-robin arbiter sharing one DMA MM2S command channel among NUM_CH
// TLK2711 TX command generators. One transfer outstanding at a time.
module tlk2711_dma_rd_arb #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DLEN_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_soft_rst,
    input  logic [NUM_CH-1:0]                        i_cmd_req,
    input  logic [NUM_CH*(ADDR_WIDTH+DLEN_WIDTH)-1:0] i_cmd_data,
    output logic [NUM_CH-1:0]                        o_cmd_ack,
    output logic [NUM_CH-1:0]                        o_dma_last,
    output logic                                     o_dma_cmd_valid,
    input  logic                                     i_dma_cmd_ready,
    output logic [ADDR_WIDTH+DLEN_WIDTH-1:0]         o_dma_cmd_data,
    input  logic                                     i_dma_rd_last,
    output logic [2:0]                               o_grant_ch,
    output logic                                     o_busy,
    output logic                                     o_zero_len,
    output logic                                     o_timeout
);

    localparam int unsigned CW    = ADDR_WIDTH + DLEN_WIDTH;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] saddr;
        logic [DLEN_WIDTH-1:0] len;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    cmd_t              cmd_q, cmd_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] last_q, last_d;
    logic              zero_q, zero_d;
    logic              tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_vld;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;
    cmd_t              pick_cmd;

    // First requester scanning upward from rr+1, wrapping modulo NUM_CH
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((32'(rr_q) + i) % NUM_CH);
            if (!pick_vld && i_cmd_req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // Command payload of the picked channel
    always_comb begin
        pick_cmd = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (pick == CH_W'(k)) begin
                pick_cmd = i_cmd_data[k*CW +: CW];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        last_d  = '0;
        zero_d  = 1'b0;
        tmo_d   = 1'b0;
        if (i_soft_rst) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Skip sampling while an ack/last pulse is on the wire so a
                    // requester that has not yet dropped req is not re-granted.
                    if (pick_vld && (ack_q == '0) && (last_q == '0)) begin
                        rr_d    = pick;
                        grant_d = pick;
                        if (pick_cmd.len == '0) begin
                            ack_d[pick]  = 1'b1;
                            last_d[pick] = 1'b1;
                            zero_d       = 1'b1;
                        end else begin
                            cmd_d   = pick_cmd;
                            valid_d = 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_dma_cmd_ready) begin
                        valid_d         = 1'b0;
                        ack_d[grant_q]  = 1'b1;
                        cnt_d           = '0;
                        state_d         = WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (i_dma_rd_last) begin
                        last_d[grant_q] = 1'b1;
                        state_d         = IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= CH_W'(NUM_CH - 1);
            grant_q <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            last_q  <= '0;
            zero_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_cmd_ack       = ack_q;
    assign o_dma_last      = last_q;
    assign o_dma_cmd_valid = valid_q;
    assign o_dma_cmd_data  = cmd_q;
    assign o_grant_ch      = 3'(grant_q);
    assign o_busy          = busy_q;
    assign o_zero_len      = zero_q;
    assign o_timeout       = tmo_q;

endmodule

// File: tb/tb_tlk2711_dma_rd_arb.sv
// Directed bench for tlk2711_dma_rd_arb with hand-computed expectations.
module tb_tlk2711_dma_rd_arb;

    localparam int unsigned CW = 48;
    localparam logic [CW-1:0] D0  = {32'h1000_0000, 16'd872};
    localparam logic [CW-1:0] D1  = {32'h2000_0040, 16'd256};
    localparam logic [CW-1:0] D1Z = {32'h3000_0000, 16'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soft_rst;
    logic [1:0]    cmd_req;
    logic [2*CW-1:0] cmd_data;
    logic [1:0]    cmd_ack;
    logic [1:0]    dma_last;
    logic          dma_cmd_valid;
    logic          dma_cmd_ready;
    logic [CW-1:0] dma_cmd_data;
    logic          dma_rd_last;
    logic [2:0]    grant_ch;
    logic          busy;
    logic          zero_len;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    tlk2711_dma_rd_arb #(
        .NUM_CH(2), .ADDR_WIDTH(32), .DLEN_WIDTH(16), .TIMEOUT_CYC(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_soft_rst      (soft_rst),
        .i_cmd_req       (cmd_req),
        .i_cmd_data      (cmd_data),
        .o_cmd_ack       (cmd_ack),
        .o_dma_last      (dma_last),
        .o_dma_cmd_valid (dma_cmd_valid),
        .i_dma_cmd_ready (dma_cmd_ready),
        .o_dma_cmd_data  (dma_cmd_data),
        .i_dma_rd_last   (dma_rd_last),
        .o_grant_ch      (grant_ch),
        .o_busy          (busy),
        .o_zero_len      (zero_len),
        .o_timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    int g;
    int ack_cnt;
    bit stable;

    initial begin
        rst_n = 1'b0; soft_rst = 1'b0; cmd_req = '0; cmd_data = '0;
        dma_cmd_ready = 1'b0; dma_rd_last = 1'b0;
        repeat (3) step();
        check("rst_valid", dma_cmd_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_grant", grant_ch, 0);
        check("rst_ack",   cmd_ack, 0);
        check("rst_last",  dma_last, 0);
        check("rst_data",  dma_cmd_data, 0);
        rst_n = 1'b1;
        step();

        // 1: single ch0 transfer, ready tied high
        cmd_data = {D1, D0}; cmd_req = 2'b01; dma_cmd_ready = 1'b1;
        step();
        check("t1_valid", dma_cmd_valid, 1);
        check("t1_data",  dma_cmd_data, 48'h1000_0000_0368);
        check("t1_grant", grant_ch, 0);
        check("t1_busy",  busy, 1);
        step();
        check("t1_ack",       cmd_ack, 2'b01);
        check("t1_valid_off", dma_cmd_valid, 0);
        cmd_req = 2'b00;
        step();
        check("t1_ack_once", cmd_ack, 2'b00);
        dma_rd_last = 1'b1;
        step();
        check("t1_last", dma_last, 2'b01);
        check("t1_idle", busy, 0);
        dma_rd_last = 1'b0;
        step();
        check("t1_last_once", dma_last, 2'b00);

        // 2: both channels requesting, strict rotation
        do_reset();
        cmd_req = 2'b11;
        step();
        for (int k = 0; k < 6; k++) begin
            g = k % 2;
            check("t2_valid", dma_cmd_valid, 1);
            check("t2_grant", grant_ch, 64'(g));
            check("t2_data",  dma_cmd_data, (g == 1) ? D1 : D0);
            step();
            check("t2_ack", cmd_ack, 64'(1 << g));
            cmd_req[g] = 1'b0;
            step();
            cmd_req[g] = 1'b1;
            dma_rd_last = 1'b1;
            step();
            check("t2_last",    dma_last, 64'(1 << g));
            check("t2_one_out", dma_cmd_valid, 0);
            dma_rd_last = 1'b0;
            step();
            check("t2_gap", dma_cmd_valid, 0);
            step();
        end
        cmd_req = 2'b00;

        // 3: zero-length on ch1, then ch0 served normally
        do_reset();
        cmd_data = {D1Z, D0}; cmd_req = 2'b10;
        step();
        check("t3_ack",   cmd_ack, 2'b10);
        check("t3_last",  dma_last, 2'b10);
        check("t3_zero",  zero_len, 1);
        check("t3_valid", dma_cmd_valid, 0);
        check("t3_grant", grant_ch, 1);
        check("t3_busy",  busy, 0);
        cmd_req = 2'b01;
        step();
        check("t3_zero_once", zero_len, 0);
        check("t3_gap",       dma_cmd_valid, 0);
        step();
        check("t3_ch0_valid", dma_cmd_valid, 1);
        check("t3_ch0_grant", grant_ch, 0);
        check("t3_ch0_data",  dma_cmd_data, D0);
        step();
        check("t3_ch0_ack", cmd_ack, 2'b01);
        cmd_req = 2'b00;
        dma_rd_last = 1'b1;
        step();
        check("t3_ch0_last", dma_last, 2'b01);
        dma_rd_last = 1'b0;
        step();

        // 4: timeout with no last, then last coinciding with expiry
        cmd_data = {D1, D0}; cmd_req = 2'b10;
        step();
        check("t4_grant", grant_ch, 1);
        step();
        check("t4_ack", cmd_ack, 2'b10);
        cmd_req = 2'b00;
        repeat (15) step();
        check("t4_no_early", timeout, 0);
        check("t4_busy",     busy, 1);
        step();
        check("t4_timeout", timeout, 1);
        check("t4_no_last", dma_last, 0);
        check("t4_idle",    busy, 0);
        step();
        check("t4_tmo_once", timeout, 0);
        cmd_req = 2'b01;
        step();
        check("t4_next_valid", dma_cmd_valid, 1);
        check("t4_next_grant", grant_ch, 0);
        step();
        check("t4_next_ack", cmd_ack, 2'b01);
        cmd_req = 2'b00;
        repeat (15) step();
        dma_rd_last = 1'b1;
        step();
        check("t4_last_wins", dma_last, 2'b01);
        check("t4_no_tmo",    timeout, 0);
        dma_rd_last = 1'b0;
        step();

        // 5: soft reset in ISSUE, re-grant, then async reset in WAIT_LAST
        cmd_req = 2'b01; dma_cmd_ready = 1'b0;
        step();
        check("t5_valid", dma_cmd_valid, 1);
        step(); step();
        check("t5_hold", dma_cmd_valid, 1);
        soft_rst = 1'b1;
        step();
        check("t5_sr_valid", dma_cmd_valid, 0);
        check("t5_sr_busy",  busy, 0);
        check("t5_sr_ack",   cmd_ack, 0);
        step(); step();
        check("t5_sr_held", dma_cmd_valid, 0);
        soft_rst = 1'b0;
        step();
        check("t5_regrant_valid", dma_cmd_valid, 1);
        check("t5_regrant_ch",    grant_ch, 0);
        dma_cmd_ready = 1'b1;
        step();
        check("t5_ack", cmd_ack, 2'b01);
        cmd_req = 2'b00;
        step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_arst_busy", busy, 0);
        check("t5_arst_data", dma_cmd_data, 0);
        step();
        rst_n = 1'b1;
        step();

        // 6: stray last in IDLE, then 10 cycles of backpressure
        dma_rd_last = 1'b1;
        step();
        check("t6_stray_last", dma_last, 0);
        check("t6_stray_busy", busy, 0);
        dma_rd_last = 1'b0;
        cmd_req = 2'b10; dma_cmd_ready = 1'b0;
        step();
        check("t6_valid", dma_cmd_valid, 1);
        check("t6_grant", grant_ch, 1);
        stable = 1'b1; ack_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (dma_cmd_data !== D1 || dma_cmd_valid !== 1'b1) stable = 1'b0;
            if (cmd_ack != 2'b00) ack_cnt++;
        end
        check("t6_stable", stable, 1);
        dma_cmd_ready = 1'b1;
        step();
        check("t6_ack", cmd_ack, 2'b10);
        if (cmd_ack != 2'b00) ack_cnt++;
        cmd_req = 2'b00;
        step();
        if (cmd_ack != 2'b00) ack_cnt++;
        check("t6_one_ack", 64'(ack_cnt), 1);
        dma_rd_last = 1'b1;
        step();
        check("t6_last", dma_last, 2'b10);
        dma_rd_last = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
